// File: rtl/ovr_hold_reg.sv
// Target register with functional writes and assign/deassign-style override that keeps the last forced value after release.
// Optional override timeout with re-arm is built when OVR_TIMEOUT_EN is defined.
module ovr_hold_reg #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ovr_req,
  input  logic [WIDTH-1:0] ovr_data,
  output logic             ovr_ack,
  output logic [WIDTH-1:0] q,
  output logic             stale,
  output logic [7:0]       drop_cnt,
  output logic             timeout_evt
);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_OVR    = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             ack_q, ack_d;
  logic             stale_q, stale_d;
  logic [7:0]       drop_q, drop_d;
  logic             drop_inc;
  logic             entry_ok;
  logic             ovr_enter;
  logic             timeout_hit;

  assign ovr_enter = entry_ok & ((state_q == ST_NORMAL) | (state_q == ST_HOLD));

`ifdef OVR_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [7:0] cnt_q, cnt_d;
  logic       rearm_q, rearm_d;
  logic       evt_q, evt_d;

  // A timed-out override may only return after ovr_req has been seen low.
  assign entry_ok    = ovr_req & ~rearm_q;
  assign timeout_hit = (state_q == ST_OVR) & ovr_req & (cnt_q == TIMEOUT_C);

  always_comb begin
    cnt_d   = cnt_q;
    rearm_d = rearm_q;
    evt_d   = 1'b0;
    if (ovr_enter) begin
      cnt_d = 8'd1;
    end else if ((state_q == ST_OVR) && ovr_req && !timeout_hit) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (timeout_hit) begin
      evt_d   = 1'b1;
      rearm_d = 1'b1;
    end else if (!ovr_req) begin
      rearm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= 8'd0;
      rearm_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rearm_q <= rearm_d;
      evt_q   <= evt_d;
    end
  end

  assign timeout_evt = evt_q;
`else
  logic unused_timeout;

  assign entry_ok       = ovr_req;
  assign timeout_hit    = 1'b0;
  assign timeout_evt    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    ack_d    = ack_q;
    stale_d  = stale_q;
    drop_inc = 1'b0;
    case (state_q)
      ST_NORMAL, ST_HOLD: begin
        if (ovr_enter) begin
          // Override wins over a same-cycle write; that write is counted as dropped.
          state_d  = ST_OVR;
          q_d      = ovr_data;
          ack_d    = 1'b1;
          stale_d  = 1'b0;
          drop_inc = wr_en;
        end else if (wr_en) begin
          state_d = ST_NORMAL;
          q_d     = wr_data;
          stale_d = 1'b0;
        end
      end
      ST_OVR: begin
        drop_inc = wr_en;
        if (!ovr_req || timeout_hit) begin
          state_d = ST_HOLD;
          ack_d   = 1'b0;
          stale_d = 1'b1;
        end else begin
          q_d = ovr_data;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
    drop_d = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      q_q     <= '0;
      ack_q   <= 1'b0;
      stale_q <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ack_q   <= ack_d;
      stale_q <= stale_d;
      drop_q  <= drop_d;
    end
  end

  assign q        = q_q;
  assign ovr_ack  = ack_q;
  assign stale    = stale_q;
  assign drop_cnt = drop_q;

endmodule
